// File: rtl/dbg_sba_master_pkg.sv
// dbg_sba_master_pkg: state encoding, sberror codes and access-size helpers
// shared by the SBA master and its lane aligner.
package dbg_sba_master_pkg;
  typedef enum logic [2:0] {IDLE, ARB, ACCESS, RDATA, RESP} state_e;
  localparam logic [2:0] ERR_OK         = 3'd0;
  localparam logic [2:0] ERR_NO_HIT     = 3'd2;
  localparam logic [2:0] ERR_MISALIGNED = 3'd3;
  localparam logic [2:0] ERR_BAD_SIZE   = 3'd4;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  function automatic logic [1:0] align_mask(input logic [1:0] size);
    return size == SIZE_BYTE ? 2'b00 : size == SIZE_HALF ? 2'b01 : 2'b11;
  endfunction
  function automatic logic [31:0] size_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction
endpackage

// File: rtl/arilla_bus_if.sv
// arilla_bus_if: shared system bus; initiator strobes are nets so that idle
// initiators can release them to high impedance.
interface arilla_bus_if;
  wire  [29:0] address;
  wire  [3:0]  byte_enable;
  wire  [31:0] data_ctp;
  wire         read;
  wire         write;
  logic        hit;
  logic [31:0] data_ptc;
  logic        intercept;
  modport initiator (output address, byte_enable, data_ctp, read, write, input hit, data_ptc);
  modport target (input address, byte_enable, data_ctp, read, write, output hit, data_ptc, intercept);
endinterface

// File: rtl/sba_lane_align.sv
// sba_lane_align: maps a right-aligned 1/2/4-byte access onto the 32-bit bus
// lanes selected by the low address bits, and extracts read data back.
module sba_lane_align
  import dbg_sba_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  byte_enable,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata
);
  logic [3:0]  lanes;
  logic [31:0] mask;
  logic [4:0]  shift;
  always_comb begin
    lanes       = size == SIZE_BYTE ? 4'b0001 : size == SIZE_HALF ? 4'b0011 : 4'b1111;
    mask        = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    shift       = {offset, 3'b000};
    byte_enable = lanes << offset;
    bus_wdata   = (wdata & mask) << shift;
    rdata       = (bus_rdata >> shift) & mask;
  end
endmodule

// File: rtl/dbg_sba_master.sv
// dbg_sba_master: debug system-bus access master, one command at a time.
// Define SBA_AUTOINCREMENT_EN to add cmd_autoinc / next_address.
module dbg_sba_master
  import dbg_sba_master_pkg::*;
#(
  parameter logic [2:0] SupportedSizes = 3'b111
) (
  input  logic                   clk,
  input  logic                   rst_n,
  arilla_bus_if.initiator        bus_interface,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [1:0]             cmd_size,
  input  logic [31:0]            cmd_address,
  input  logic [31:0]            cmd_wdata,
`ifdef SBA_AUTOINCREMENT_EN
  input  logic                   cmd_autoinc,
  output logic [31:0]            next_address,
`endif
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic [2:0]             rsp_error
);
  state_e      state_q, state_d;
  logic        live_q;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]  err_q, err_d, chk_err;
  logic [31:0] cmd_addr, bus_wdata, rd_data;
  logic [3:0]  be, sup;
  logic        in_access;

`ifdef SBA_AUTOINCREMENT_EN
  logic [31:0] next_q, next_d;
  assign cmd_addr     = cmd_autoinc ? next_q : cmd_address;
  assign next_address = next_q;
  always_comb next_d = (state_q == ACCESS && bus_interface.hit) ? addr_q + size_bytes(size_q) : next_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) next_q <= '0;
    else next_q <= next_d;
  end
`else
  assign cmd_addr = cmd_address;
`endif

  // size 3 lands on the zero pad, so one lookup covers both size errors
  assign sup       = {1'b0, SupportedSizes};
  assign chk_err   = !sup[cmd_size] ? ERR_BAD_SIZE
                   : |(cmd_addr[1:0] & align_mask(cmd_size)) ? ERR_MISALIGNED : ERR_OK;
  assign cmd_ready = live_q && state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;
  assign bus_req   = state_q == ARB || state_q == ACCESS || state_q == RDATA;
  assign in_access = state_q == ACCESS;

  sba_lane_align u_align (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .bus_rdata  (bus_interface.data_ptc),
    .byte_enable(be),
    .bus_wdata  (bus_wdata),
    .rdata      (rd_data)
  );

  assign bus_interface.address     = in_access ? addr_q[31:2] : {30{1'bz}};
  assign bus_interface.byte_enable = in_access ? be : 4'bzzzz;
  assign bus_interface.data_ctp    = in_access ? bus_wdata : {32{1'bz}};
  assign bus_interface.read        = in_access ? !write_q : 1'bz;
  assign bus_interface.write       = in_access ? write_q : 1'bz;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (cmd_ready && cmd_valid) begin
        write_d = cmd_write;
        size_d  = cmd_size;
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        rdata_d = '0;
        err_d   = chk_err;
        state_d = chk_err == ERR_OK ? ARB : RESP;
      end
      ARB: state_d = bus_gnt ? ACCESS : ARB;
      ACCESS: begin
        err_d   = bus_interface.hit ? ERR_OK : ERR_NO_HIT;
        state_d = (bus_interface.hit && !write_q) ? RDATA : RESP;
      end
      RDATA: begin
        rdata_d = rd_data;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps cmd_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      write_q <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_dbg_sba_master.sv
// tb_dbg_sba_master: scoreboard bench for dbg_sba_master with a simple target
// that maps byte addresses below 0x4000 and returns data one cycle after a read.
module tb_dbg_sba_master;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        bus_req, bus_gnt = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [1:0]  cmd_size = 2'd0;
  logic [31:0] cmd_address = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_error;
  logic [31:0] tgt_word = 32'h0;
`ifdef SBA_AUTOINCREMENT_EN
  logic        cmd_autoinc = 1'b0;
  logic [31:0] next_address;
`endif
  int pass = 0, total = 0;

  arilla_bus_if bif();

  dbg_sba_master dut (
    .clk(clk), .rst_n(rst_n), .bus_interface(bif), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_size(cmd_size),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
`ifdef SBA_AUTOINCREMENT_EN
    .cmd_autoinc(cmd_autoinc), .next_address(next_address),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  assign bif.hit       = (bif.read === 1'b1 || bif.write === 1'b1) && (bif.address < 30'h1000);
  assign bif.intercept = 1'b0;
  always @(posedge clk) bif.data_ptc <= (bif.read === 1'b1) ? tgt_word : 32'h0;

  typedef struct { logic [31:0] rdata; logic [2:0] err; } exp_t;
  typedef struct {
    logic [31:0] rdata; logic [2:0] err; int lat; int accesses;
    logic [29:0] addr; logic [3:0] be; logic [31:0] dctp; logic rd; logic wr;
    bit req_gap; bit req_seen; bit req_in_resp; bit unstable;
  } obs_t;
  typedef struct { logic w; logic [1:0] sz; logic [31:0] a; logic [31:0] wd; } cmd_t;
  exp_t exp_q[$];

  function automatic bit strobe();
    return bif.read === 1'b1 || bif.write === 1'b1;
  endfunction

  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] word);
    exp_t e;
    int nb = 1 << sz;
    int off = int'(a % 4);
    logic [63:0] m = (64'd1 << (8 * nb)) - 64'd1;
    logic [63:0] rd = ({32'd0, word} >> (8 * off)) & m;
    e.err   = sz == 2'd3 ? 3'd4 : (a % nb != 0) ? 3'd3 : (a >= 32'h4000) ? 3'd2 : 3'd0;
    e.rdata = (w || e.err != 3'd0) ? 32'd0 : rd[31:0];
    return e;
  endfunction

  task automatic run_cmd(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input int gnt_delay, input int rdy_delay, output obs_t o);
    int lat = 0;
    o = '{default: 0};
    bus_gnt = gnt_delay == 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_address = a; cmd_wdata = wd;
    while (cmd_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (bus_req === 1'b1) o.req_seen = 1;
      else if (o.accesses == 0) o.req_gap = 1;
      if (strobe()) begin
        o.accesses++;
        o.addr = bif.address; o.be = bif.byte_enable; o.dctp = bif.data_ctp;
        o.rd = bif.read; o.wr = bif.write;
        if (gnt_delay > 0) bus_gnt = 1'b0;
      end
      if (gnt_delay > 0 && lat == gnt_delay + 1) bus_gnt = 1'b1;
      @(negedge clk); lat++;
    end
    o.lat = lat; o.rdata = rsp_rdata; o.err = rsp_error; o.req_in_resp = bus_req;
    if (strobe()) o.accesses++;
    for (int i = 0; i < rdy_delay; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_error !== o.err || bus_req !== 1'b0) o.unstable = 1;
      if (strobe()) o.accesses++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    bus_gnt = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (cmd_ready !== 1'b0) $display("FAIL rst cmd_ready got %b want 0", cmd_ready); else pass++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst rsp_valid got %b want 0", rsp_valid); else pass++;
    total++; if (rsp_rdata !== 32'h0 || rsp_error !== 3'd0) $display("FAIL rst rsp fields got %h/%0d want 0/0", rsp_rdata, rsp_error); else pass++;
    total++; if (bus_req !== 1'b0) $display("FAIL rst bus_req got %b want 0", bus_req); else pass++;
    total++; if (strobe()) $display("FAIL rst bus strobes got rd=%b wr=%b want released", bif.read, bif.write); else pass++;
`ifdef SBA_AUTOINCREMENT_EN
    total++; if (next_address !== 32'h0) $display("FAIL rst next_address got %h want 0", next_address); else pass++;
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b0) $display("FAIL rst release cmd_ready early got %b want 0", cmd_ready); else pass++;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL rst first edge cmd_ready got %b want 1", cmd_ready); else pass++;
  endtask

  task automatic test_write_word();
    obs_t o; exp_t e;
    exp_q.push_back(model(1'b1, 2'd2, 32'h100, tgt_word));
    run_cmd(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 0, 0, o);
    e = exp_q.pop_front();
    total++; if (o.err !== e.err || o.rdata !== e.rdata) $display("FAIL wr_word rsp got %0d/%h want %0d/%h", o.err, o.rdata, e.err, e.rdata); else pass++;
    total++; if (o.lat != 3) $display("FAIL wr_word latency got %0d want 3", o.lat); else pass++;
    total++; if (o.accesses != 1 || o.addr !== 30'h40 || o.wr !== 1'b1 || o.rd !== 1'b0) $display("FAIL wr_word bus got n=%0d addr=%h rd=%b wr=%b want 1/40/0/1", o.accesses, o.addr, o.rd, o.wr); else pass++;
    total++; if (o.be !== 4'b1111 || o.dctp !== 32'hDEADBEEF) $display("FAIL wr_word lanes got be=%b d=%h want 1111/deadbeef", o.be, o.dctp); else pass++;
  endtask

  task automatic test_read_byte();
    obs_t o; exp_t e;
    tgt_word = 32'h11223344;
    exp_q.push_back(model(1'b0, 2'd0, 32'h103, tgt_word));
    run_cmd(1'b0, 2'd0, 32'h103, 32'h0, 0, 0, o);
    e = exp_q.pop_front();
    total++; if (o.rdata !== 32'h00000011 || o.rdata !== e.rdata) $display("FAIL rd_byte rdata got %h want %h", o.rdata, e.rdata); else pass++;
    total++; if (o.err !== e.err) $display("FAIL rd_byte err got %0d want %0d", o.err, e.err); else pass++;
    total++; if (o.lat != 4) $display("FAIL rd_byte latency got %0d want 4", o.lat); else pass++;
    total++; if (o.be !== 4'b1000 || o.addr !== 30'h40 || o.rd !== 1'b1) $display("FAIL rd_byte bus got be=%b addr=%h rd=%b want 1000/40/1", o.be, o.addr, o.rd); else pass++;
  endtask

  task automatic test_errors();
    cmd_t tbl[4];
    obs_t o; exp_t e;
    tbl = '{'{1'b0, 2'd1, 32'h101, 32'h0}, '{1'b0, 2'd3, 32'h100, 32'h0},
            '{1'b0, 2'd3, 32'h101, 32'h0}, '{1'b1, 2'd2, 32'h102, 32'h5}};
    foreach (tbl[i]) begin
      exp_q.push_back(model(tbl[i].w, tbl[i].sz, tbl[i].a, tgt_word));
      run_cmd(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, 0, 0, o);
      e = exp_q.pop_front();
      total++; if (o.err !== e.err || o.rdata !== 32'h0) $display("FAIL err[%0d] rsp got %0d/%h want %0d/0", i, o.err, o.rdata, e.err); else pass++;
      total++; if (o.accesses != 0 || o.req_seen || o.lat != 1) $display("FAIL err[%0d] bus got n=%0d req=%0b lat=%0d want 0/0/1", i, o.accesses, o.req_seen, o.lat); else pass++;
    end
  endtask

  task automatic test_unmapped();
    obs_t o; exp_t e;
    exp_q.push_back(model(1'b0, 2'd2, 32'h10000, tgt_word));
    run_cmd(1'b0, 2'd2, 32'h10000, 32'h0, 0, 0, o);
    e = exp_q.pop_front();
    total++; if (o.err !== 3'd2 || o.err !== e.err || o.rdata !== 32'h0) $display("FAIL unmapped rsp got %0d/%h want 2/0", o.err, o.rdata); else pass++;
    total++; if (o.accesses != 1 || o.lat != 3) $display("FAIL unmapped bus got n=%0d lat=%0d want 1/3", o.accesses, o.lat); else pass++;
  endtask

  task automatic test_lanes();
    cmd_t tbl[6];
    obs_t o; exp_t e;
    tgt_word = 32'hCAFEF00D;
    tbl = '{'{1'b1, 2'd0, 32'h102, 32'h000000AB}, '{1'b1, 2'd1, 32'h102, 32'h12345678},
            '{1'b0, 2'd1, 32'h102, 32'h0}, '{1'b0, 2'd1, 32'h100, 32'h0},
            '{1'b0, 2'd0, 32'h101, 32'h0}, '{1'b0, 2'd2, 32'h104, 32'h0}};
    foreach (tbl[i]) begin
      int nb = 1 << tbl[i].sz;
      int off = int'(tbl[i].a % 4);
      logic [63:0] m = (64'd1 << (8 * nb)) - 64'd1;
      logic [63:0] d = ({32'd0, tbl[i].wd} & m) << (8 * off);
      logic [7:0] be = 8'(((1 << nb) - 1) << off);
      exp_q.push_back(model(tbl[i].w, tbl[i].sz, tbl[i].a, tgt_word));
      run_cmd(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, 0, 0, o);
      e = exp_q.pop_front();
      total++; if (o.rdata !== e.rdata || o.err !== e.err) $display("FAIL lane[%0d] rsp got %h/%0d want %h/%0d", i, o.rdata, o.err, e.rdata, e.err); else pass++;
      total++; if (o.be !== be[3:0] || o.wr !== tbl[i].w) $display("FAIL lane[%0d] be got %b wr=%b want %b wr=%b", i, o.be, o.wr, be[3:0], tbl[i].w); else pass++;
      if (tbl[i].w) begin
        total++; if (o.dctp !== d[31:0]) $display("FAIL lane[%0d] data_ctp got %h want %h", i, o.dctp, d[31:0]); else pass++;
      end
    end
  endtask

  task automatic test_stall();
    obs_t o; exp_t e;
    tgt_word = 32'h55AA1234;
    exp_q.push_back(model(1'b0, 2'd2, 32'h108, tgt_word));
    run_cmd(1'b0, 2'd2, 32'h108, 32'h0, 5, 3, o);
    e = exp_q.pop_front();
    total++; if (o.rdata !== e.rdata || o.err !== e.err) $display("FAIL stall rsp got %h/%0d want %h/%0d", o.rdata, o.err, e.rdata, e.err); else pass++;
    total++; if (o.req_gap || o.lat != 9) $display("FAIL stall arb got gap=%0b lat=%0d want 0/9", o.req_gap, o.lat); else pass++;
    total++; if (o.unstable || o.req_in_resp) $display("FAIL stall resp hold got unstable=%0b req=%b want 0/0", o.unstable, o.req_in_resp); else pass++;
    total++; if (o.accesses != 1) $display("FAIL stall accesses got %0d want 1", o.accesses); else pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    tgt_word = 32'h0BADF00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_address = 32'h10C;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!strobe() && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) $display("FAIL rst_mid access got none want one within 20 cycles"); else pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || bus_req !== 1'b0 || strobe()) $display("FAIL rst_mid immediate got v=%b rdy=%b req=%b want 0/0/0", rsp_valid, cmd_ready, bus_req); else pass++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rst_mid release got rdy=%b v=%b want 1/0", cmd_ready, rsp_valid); else pass++;
  endtask

`ifdef SBA_AUTOINCREMENT_EN
  task automatic test_autoinc();
    obs_t o; exp_t e;
    cmd_autoinc = 1'b0;
    exp_q.push_back(model(1'b1, 2'd2, 32'h200, tgt_word));
    run_cmd(1'b1, 2'd2, 32'h200, 32'h1, 0, 0, o);
    e = exp_q.pop_front();
    total++; if (o.addr !== 30'h80 || o.err !== e.err || next_address !== 32'h204) $display("FAIL autoinc first got addr=%h err=%0d next=%h want 80/0/204", o.addr, o.err, next_address); else pass++;
    cmd_autoinc = 1'b1;
    exp_q.push_back(model(1'b1, 2'd2, 32'h204, tgt_word));
    run_cmd(1'b1, 2'd2, 32'hFFFFFFF0, 32'h2, 0, 0, o);
    e = exp_q.pop_front();
    cmd_autoinc = 1'b0;
    total++; if (o.addr !== 30'h81 || o.err !== e.err) $display("FAIL autoinc second got addr=%h err=%0d want 81/%0d", o.addr, o.err, e.err); else pass++;
    total++; if (next_address !== 32'h208) $display("FAIL autoinc next got %h want 208", next_address); else pass++;
  endtask
`endif

  initial begin
    #2 rst_n = 1'b0;
    test_reset();
    test_write_word();
    test_read_byte();
    test_errors();
    test_unmapped();
    test_lanes();
    test_stall();
    test_reset_mid();
`ifdef SBA_AUTOINCREMENT_EN
    test_autoinc();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
